irq_sequencer: RTL and testbench

//  Sequential interrupt controller between peripheral IRQ lines and the RV32IC core's trap logic.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_sequencer.sv | 112 +++++++++++
 tb/tb_irq_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and FSM state type for the interrupt
//               sequencer (line count, id width, reset mask, states).
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = $clog2(NUM_IRQ);

    localparam logic [NUM_IRQ-1:0] MASK_RST_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Fixed-priority encoder; lowest set index of the eligible
//               vector wins.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    output logic               any,
    output logic [ID_W-1:0]    sel
);

    // Scan from the top down so the lowest set index overwrites last
    always_comb begin
        any = |eligible;
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Edge-detecting, maskable interrupt controller presenting one
//               non-nesting interrupt at a time via req/ack/eoi handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer
    import irq_pkg::*;
#(
    parameter logic [NUM_IRQ-1:0] MASK_RST = MASK_RST_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending_q,
    output logic [NUM_IRQ-1:0] mask_q
);

    state_t             state;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic               any_eligible;
    logic [ID_W-1:0]    sel;
    logic               withdraw;

    // irq_prev resets low, so a line held high at reset release is an edge
    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending_q & ~mask_q;
    assign withdraw = mask_q[int_id] | ~pending_q[int_id];

    // Acknowledge clears exactly the presented line, and only while in REQ
    always_comb begin
        clr = '0;
        if (state == REQ && int_ack) begin
            clr[int_id] = 1'b1;
        end
    end

    irq_prio_enc u_prio_enc (
        .eligible (eligible),
        .any      (any_eligible),
        .sel      (sel)
    );

    // Edge history, sticky pending bits (set beats clear) and mask register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev  <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RST;
        end else begin
            irq_prev  <= irq_in;
            pending_q <= (pending_q & ~clr) | rise;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Handshake FSM with registered outputs; int_id is frozen outside IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        int_id  <= sel;
                        int_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SVC;
                    end else if (withdraw) begin
                        int_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                SVC: begin
                    if (eoi) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Table-driven self-checking bench for irq_sequencer, plus a
//               hand-written asynchronous-reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       int_req;
    logic [2:0] int_id;
    logic       in_service;
    logic [7:0] pending_q;
    logic [7:0] mask_q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_id     (int_id),
        .in_service (in_service),
        .pending_q  (pending_q),
        .mask_q     (mask_q)
    );

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mwd;
        logic       ack;
        logic       eoi;
        logic       req;
        logic [2:0] id;
        logic       svc;
        logic [7:0] pend;
        logic [7:0] mask;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [7:0] irq, input logic mwe,
                       input logic [7:0] mwd, input logic ack, input logic e,
                       input logic req, input logic [2:0] id, input logic svc,
                       input logic [7:0] pend, input logic [7:0] mask);
        vec_t v;
        v.rst = r; v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.eoi = e;
        v.req = req; v.id = id; v.svc = svc; v.pend = pend; v.mask = mask;
        vq.push_back(v);
    endtask

    // Observed outputs packed as {req, id, svc, pend, mask}
    function automatic logic [20:0] obs();
        return {int_req, int_id, in_service, pending_q, mask_q};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got req=%b id=%0d svc=%b pend=%h mask=%h, want req=%b id=%0d svc=%b pend=%h mask=%h",
                     name, act[20], act[19:17], act[16], act[15:8], act[7:0],
                     exp[20], exp[19:17], exp[16], exp[15:8], exp[7:0]);
        end
    endtask

    initial begin
        int cycles;
        //   rst irq   we wd    ack eoi | req id svc pend  mask
        // reset and unmask
        add(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 8'h00, 8'hFF); // 0
        add(0, 8'h00, 1, 8'h00, 0, 0,   0, 0, 0, 8'h00, 8'h00); // 1
        // single pulse on line 5: pending next cycle, request one later
        add(0, 8'h20, 0, 8'h00, 0, 0,   0, 0, 0, 8'h20, 8'h00); // 2
        add(0, 8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20, 8'h00); // 3
        add(0, 8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h00, 8'h00); // 4
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 5, 0, 8'h00, 8'h00); // 5
        // lines 2 and 7 together: 2 first, then 7
        add(0, 8'h84, 0, 8'h00, 0, 0,   0, 5, 0, 8'h84, 8'h00); // 6
        add(0, 8'h84, 0, 8'h00, 0, 0,   1, 2, 0, 8'h84, 8'h00); // 7
        add(0, 8'h84, 0, 8'h00, 1, 0,   0, 2, 1, 8'h80, 8'h00); // 8
        add(0, 8'h84, 0, 8'h00, 0, 1,   0, 2, 0, 8'h80, 8'h00); // 9
        add(0, 8'h84, 0, 8'h00, 0, 0,   1, 7, 0, 8'h80, 8'h00); // 10
        add(0, 8'h84, 0, 8'h00, 1, 0,   0, 7, 1, 8'h00, 8'h00); // 11
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 7, 0, 8'h00, 8'h00); // 12
        // masked line 3 stays pending until unmasked
        add(0, 8'h00, 1, 8'h08, 0, 0,   0, 7, 0, 8'h00, 8'h08); // 13
        add(0, 8'h08, 0, 8'h00, 0, 0,   0, 7, 0, 8'h08, 8'h08); // 14
        add(0, 8'h08, 0, 8'h00, 0, 0,   0, 7, 0, 8'h08, 8'h08); // 15
        add(0, 8'h08, 1, 8'h00, 0, 0,   0, 7, 0, 8'h08, 8'h00); // 16
        add(0, 8'h08, 0, 8'h00, 0, 0,   1, 3, 0, 8'h08, 8'h00); // 17
        add(0, 8'h08, 0, 8'h00, 1, 0,   0, 3, 1, 8'h00, 8'h00); // 18
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 3, 0, 8'h00, 8'h00); // 19
        // line 0 arrives while servicing line 1; spurious ack/eoi ignored
        add(0, 8'h02, 0, 8'h00, 0, 0,   0, 3, 0, 8'h02, 8'h00); // 20
        add(0, 8'h02, 0, 8'h00, 0, 0,   1, 1, 0, 8'h02, 8'h00); // 21
        add(0, 8'h02, 0, 8'h00, 1, 0,   0, 1, 1, 8'h00, 8'h00); // 22
        add(0, 8'h03, 0, 8'h00, 0, 0,   0, 1, 1, 8'h01, 8'h00); // 23
        add(0, 8'h03, 0, 8'h00, 1, 0,   0, 1, 1, 8'h01, 8'h00); // 24
        add(0, 8'h03, 0, 8'h00, 0, 0,   0, 1, 1, 8'h01, 8'h00); // 25
        add(0, 8'h03, 0, 8'h00, 0, 1,   0, 1, 0, 8'h01, 8'h00); // 26
        add(0, 8'h03, 0, 8'h00, 0, 0,   1, 0, 0, 8'h01, 8'h00); // 27
        add(0, 8'h03, 0, 8'h00, 0, 1,   1, 0, 0, 8'h01, 8'h00); // 28
        add(0, 8'h03, 0, 8'h00, 1, 0,   0, 0, 1, 8'h00, 8'h00); // 29
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 8'h00, 8'h00); // 30
        // masking line 4 while requested withdraws it; stays pending
        add(0, 8'h10, 0, 8'h00, 0, 0,   0, 0, 0, 8'h10, 8'h00); // 31
        add(0, 8'h10, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10, 8'h00); // 32
        add(0, 8'h10, 1, 8'h10, 0, 0,   1, 4, 0, 8'h10, 8'h10); // 33
        add(0, 8'h10, 0, 8'h00, 0, 0,   0, 4, 0, 8'h10, 8'h10); // 34
        add(0, 8'h10, 0, 8'h00, 0, 0,   0, 4, 0, 8'h10, 8'h10); // 35
        // unmask, then ack and eoi together: only ack honoured
        add(0, 8'h10, 1, 8'h00, 0, 0,   0, 4, 0, 8'h10, 8'h00); // 36
        add(0, 8'h10, 0, 8'h00, 0, 0,   1, 4, 0, 8'h10, 8'h00); // 37
        add(0, 8'h10, 0, 8'h00, 1, 1,   0, 4, 1, 8'h00, 8'h00); // 38
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 4, 0, 8'h00, 8'h00); // 39
        // repeated edges on line 6 merge into one service
        add(0, 8'h40, 0, 8'h00, 0, 0,   0, 4, 0, 8'h40, 8'h00); // 40
        add(0, 8'h00, 0, 8'h00, 0, 0,   1, 6, 0, 8'h40, 8'h00); // 41
        add(0, 8'h40, 0, 8'h00, 0, 0,   1, 6, 0, 8'h40, 8'h00); // 42
        add(0, 8'h00, 0, 8'h00, 1, 0,   0, 6, 1, 8'h00, 8'h00); // 43
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 6, 0, 8'h00, 8'h00); // 44
        add(0, 8'h00, 0, 8'h00, 0, 0,   0, 6, 0, 8'h00, 8'h00); // 45
        // new edge coinciding with ack of the same line: set wins
        add(0, 8'h20, 0, 8'h00, 0, 0,   0, 6, 0, 8'h20, 8'h00); // 46
        add(0, 8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20, 8'h00); // 47
        add(0, 8'h20, 0, 8'h00, 1, 0,   0, 5, 1, 8'h20, 8'h00); // 48
        add(0, 8'h20, 0, 8'h00, 0, 1,   0, 5, 0, 8'h20, 8'h00); // 49
        add(0, 8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 8'h20, 8'h00); // 50
        add(0, 8'h00, 0, 8'h00, 1, 0,   0, 5, 1, 8'h00, 8'h00); // 51
        add(0, 8'h00, 0, 8'h00, 0, 1,   0, 5, 0, 8'h00, 8'h00); // 52

        foreach (vq[k]) begin
            @(negedge clk);
            rst        = vq[k].rst;
            irq_in     = vq[k].irq;
            mask_we    = vq[k].mwe;
            mask_wdata = vq[k].mwd;
            int_ack    = vq[k].ack;
            eoi        = vq[k].eoi;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), obs(),
                  {vq[k].req, vq[k].id, vq[k].svc, vq[k].pend, vq[k].mask});
        end

        // Asynchronous reset in the middle of a request with everything pending
        @(negedge clk);
        irq_in = 8'hFF; mask_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        @(posedge clk); #1;
        check("all_pending", obs(), {1'b0, 3'd5, 1'b0, 8'hFF, 8'h00});
        @(posedge clk); #1;
        check("all_req", obs(), {1'b1, 3'd0, 1'b0, 8'hFF, 8'h00});
        #2 rst = 1'b1;
        #1;
        check("async_rst", obs(), {1'b0, 3'd0, 1'b0, 8'h00, 8'hFF});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("relatch", obs(), {1'b0, 3'd0, 1'b0, 8'hFF, 8'hFF});
        @(negedge clk);
        mask_we = 1'b1; mask_wdata = 8'h00;
        @(posedge clk); #1;
        check("unmask_all", obs(), {1'b0, 3'd0, 1'b0, 8'hFF, 8'h00});
        @(negedge clk);
        mask_we = 1'b0;
        cycles = 0;
        while (cycles < 8) begin
            @(posedge clk); #1;
            cycles++;
            if (int_req) break;
        end
        total++;
        if (!int_req || cycles != 1) begin
            bad++;
            $display("FAIL req_latency: got req=%b after %0d cycles, want req=1 after 1 cycle",
                     int_req, cycles);
        end
        check("req_after_rst", obs(), {1'b1, 3'd0, 1'b0, 8'hFF, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
